// File: rtl/ascii_hex_word_parser.sv
// Parses ASCII hex words terminated by CR/LF from a UART byte stream into a W-bit value.
// Outputs are registered one edge after the sampled byte; an idle gap abandons a partial word.
module ascii_hex_word_parser #(
  parameter int DIGITS         = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [4*DIGITS-1:0] value,
  output logic                value_valid,
  output logic                parse_error,
  output logic                busy
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int GW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t        state_q;
  logic [W-1:0]  shift_q;
  logic [W-1:0]  shift_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [GW-1:0] gap_q;
  logic [W-1:0]  value_q;
  logic          value_valid_q;
  logic          parse_error_q;

  logic          is_digit;
  logic          is_term;
  logic [3:0]    nibble;

  always_comb begin
    is_digit = 1'b0;
    nibble   = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      is_digit = 1'b1;
      nibble   = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      is_digit = 1'b1;
      nibble   = rx_data[3:0] + 4'd9;
    end
  end

  assign is_term = (rx_data == 8'h0D) || (rx_data == 8'h0A);
  assign shift_d = (shift_q << 4) | W'(nibble);
  assign cnt_d   = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      gap_q         <= '0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      parse_error_q <= 1'b0;
    end else begin
      value_valid_q <= 1'b0;
      parse_error_q <= 1'b0;
      if (rx_valid) begin
        // A byte on the timeout cycle wins: it is processed and the gap restarts.
        gap_q <= '0;
        case (state_q)
          IDLE: begin
            if (is_digit) begin
              shift_q <= W'(nibble);
              cnt_q   <= CW'(1);
              state_q <= ACCUM;
            end else if (!is_term) begin
              parse_error_q <= 1'b1;
              state_q       <= DISCARD;
            end
          end
          ACCUM: begin
            if (is_digit && cnt_q != CNT_FULL) begin
              shift_q <= shift_d;
              cnt_q   <= cnt_d;
            end else if (is_term) begin
              value_q       <= shift_q;
              value_valid_q <= 1'b1;
              shift_q       <= '0;
              cnt_q         <= '0;
              state_q       <= IDLE;
            end else begin
              parse_error_q <= 1'b1;
              shift_q       <= '0;
              cnt_q         <= '0;
              state_q       <= DISCARD;
            end
          end
          DISCARD: begin
            if (is_term) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE) begin
        if (gap_q == GAP_LAST) begin
          parse_error_q <= (state_q == ACCUM);
          state_q       <= IDLE;
          gap_q         <= '0;
          shift_q       <= '0;
          cnt_q         <= '0;
        end else begin
          gap_q <= gap_q + 1'b1;
        end
      end
    end
  end

  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign parse_error = parse_error_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ascii_hex_word_parser.sv
// Scoreboard bench for ascii_hex_word_parser with DIGITS=4 and a short idle timeout.
module tb_ascii_hex_word_parser;

  localparam int DIGITS = 4;
  localparam int TMO    = 16;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] value;
  logic        value_valid;
  logic        parse_error;
  logic        busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          vv_cnt  = 0;
  int          err_cnt = 0;
  int          exp_vv  = 0;
  int          exp_err = 0;
  logic [15:0] exp_val = 16'h0000;
  logic [15:0] exp_q[$];

  ascii_hex_word_parser #(.DIGITS(DIGITS), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .value       (value),
    .value_valid (value_valid),
    .parse_error (parse_error),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (value_valid && parse_error) check("exclusive_pulse", 32'd1, 32'd0);
    if (value_valid) begin
      vv_cnt++;
      if (exp_q.size() == 0) check("unexpected_value_valid", 32'(value), 32'hFFFF_FFFF);
      else check("sb_value", 32'(value), 32'(exp_q.pop_front()));
    end
    if (parse_error) err_cnt++;
  end

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic expect_word(input logic [15:0] v);
    exp_q.push_back(v);
    exp_vv++;
    exp_val = v;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle(input string tag);
    idle(2);
    check({tag, "_vv_count"}, 32'(vv_cnt), 32'(exp_vv));
    check({tag, "_err_count"}, 32'(err_cnt), 32'(exp_err));
    check({tag, "_value"}, 32'(value), 32'(exp_val));
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(2);
    check("rst_value", 32'(value), 32'd0);
    check("rst_vv", 32'(value_valid), 32'd0);
    check("rst_perr", 32'(parse_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Mixed-case word
    send_str("1");
    check("busy_accum", 32'(busy), 32'd1);
    send_str("a3F");
    expect_word(16'h1A3F);
    send(8'h0D);
    settle("w1a3f");

    // LF terminator, then an empty CR-LF line
    send_str("7");
    expect_word(16'h0007);
    send(8'h0A);
    send(8'h0D);
    send(8'h0A);
    settle("w7");

    // Overflow on fifth digit
    send_str("1234");
    exp_err++;
    send_str("5");
    check("busy_discard", 32'(busy), 32'd1);
    send(8'h0D);
    settle("overflow");

    // Invalid char mid-word, then a good word
    send_str("1G2");
    exp_err++;
    send(8'h0D);
    send_str("BEEF");
    expect_word(16'hBEEF);
    send(8'h0D);
    settle("beef");

    // Digit-range boundaries and neighbours
    send_str("09fA");
    expect_word(16'h09FA);
    send(8'h0D);
    settle("w09fa");
    send_str("1:");
    exp_err++;
    send(8'h0D);
    send(8'h60);
    exp_err++;
    send(8'h0A);
    send_str("@");
    exp_err++;
    send(8'h0D);
    settle("bad_chars");

    // Timeout mid-word
    send_str("AB");
    idle(TMO - 1);
    check("tmo_not_yet_err", 32'(err_cnt), 32'(exp_err));
    check("tmo_not_yet_busy", 32'(busy), 32'd1);
    idle(1);
    exp_err++;
    check("tmo_err", 32'(err_cnt), 32'(exp_err));
    check("tmo_busy", 32'(busy), 32'd0);
    send_str("C");
    expect_word(16'h000C);
    send(8'h0D);
    settle("after_tmo");

    // Byte arriving on the timeout cycle is processed
    send_str("A");
    idle(TMO - 1);
    send_str("B");
    expect_word(16'h00AB);
    send(8'h0D);
    settle("coincide");

    // Timeout in DISCARD: silent return to IDLE
    send_str("Z");
    exp_err++;
    idle(TMO);
    check("discard_tmo_busy", 32'(busy), 32'd0);
    send_str("5");
    expect_word(16'h0005);
    send(8'h0D);
    settle("discard_tmo");

    // Data with rx_valid low is ignored
    rx_data = 8'h41;
    idle(3);
    rx_data = 8'h0D;
    idle(3);
    settle("valid_low");

    // Reset mid-word
    send_str("12");
    rst_n = 1'b0;
    #1;
    check("midrst_value", 32'(value), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_vv", 32'(value_valid), 32'd0);
    check("midrst_perr", 32'(parse_error), 32'd0);
    exp_val = 16'h0000;
    idle(2);
    rst_n = 1'b1;
    send_str("3");
    expect_word(16'h0003);
    send(8'h0D);
    settle("after_rst");

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ascii_hex_word_parser.md
ASCII_HEX_WORD_PARSER -- requirements
Module: ascii_hex_word_parser

Interface
REQ-001: Parameter DIGITS, default 4, maximum number of hex digits per word; value width W = 4*DIGITS.
REQ-002: Parameter TIMEOUT_CYCLES, default 1_000_000, idle-gap limit in clk cycles while a word is partially received.
REQ-003: clk  input  1  single system clock; all logic on rising edge.
REQ-004: rst_n  input  1  asynchronous, active-low reset.
REQ-005: rx_data  input  8  received UART byte, ASCII.
REQ-006: rx_valid  input  1  one-cycle strobe; rx_data valid when high.
REQ-007: value  output  W  last successfully parsed word, right-justified, zero-extended.
REQ-008: value_valid  output  1  one-cycle pulse; value updated this cycle.
REQ-009: parse_error  output  1  one-cycle pulse on any rejected word.
REQ-010: busy  output  1  high while state is ACCUM or DISCARD.

Function
REQ-011: Hex digit set SHALL be 0x30-0x39 -> 0-9, 0x41-0x46 -> A-F, 0x61-0x66 -> a-f (case-insensitive); terminator set SHALL be 0x0D (CR) and 0x0A (LF); every other byte SHALL be invalid.
REQ-012: FSM SHALL have exactly three states: IDLE, ACCUM, DISCARD.
REQ-013: IDLE + digit -> shift register = digit (zero-extended), digit count = 1, go ACCUM.
REQ-014: IDLE + terminator -> stay IDLE, no pulse (empty lines and CR-LF pairs ignored).
REQ-015: IDLE + invalid byte -> parse_error pulse, go DISCARD.
REQ-016: ACCUM + digit with count < DIGITS -> shift register = (shift register << 4) | digit, count + 1.
REQ-017: ACCUM + digit with count == DIGITS -> overflow: parse_error pulse, go DISCARD; value unchanged.
REQ-018: ACCUM + terminator -> value = shift register, value_valid pulse, go IDLE.
REQ-019: ACCUM + invalid byte -> parse_error pulse, go DISCARD.
REQ-020: DISCARD SHALL ignore all bytes except a terminator, which returns FSM to IDLE with no pulse.
REQ-021: Latency: value, value_valid and parse_error SHALL update on the clock edge that samples the triggering rx_valid byte (registered outputs, visible the following cycle); no combinational path from rx_data to outputs.
REQ-022: Gap counter SHALL clear on every rx_valid and count clk cycles in ACCUM or DISCARD without rx_valid; reaching TIMEOUT_CYCLES SHALL go IDLE, pulse parse_error only if leaving ACCUM, clear count and shift register.
REQ-023: If rx_valid coincides with the timeout cycle, the byte SHALL be processed and the counter cleared; no timeout occurs.
REQ-024: value_valid and parse_error SHALL never be high in the same cycle; each pulse SHALL last exactly one cycle.
REQ-025: value SHALL hold its last valid word indefinitely; errors and timeouts never modify it.
REQ-026: Bytes with rx_valid low SHALL be ignored regardless of rx_data.

Reset
REQ-027: rst_n low SHALL immediately force state IDLE, value = 0, shift register = 0, count = 0, gap counter = 0, value_valid = 0, parse_error = 0, busy = 0.
REQ-028: Reset asserted mid-word SHALL discard the partial word; first byte after release is treated as a word start.
REQ-029: Reset release SHALL be sampled synchronously to clk for the first state transition.

Verification
REQ-030: Bytes "1","a","3","F",CR -> one value_valid pulse, value = 16'h1A3F, parse_error never asserted.
REQ-031: Bytes "7",LF then CR,LF -> value = 16'h0007 with one pulse; the extra CR,LF produce no pulse.
REQ-032: Bytes "12345",CR (DIGITS=4) -> parse_error pulse on "5", no value_valid, value keeps prior 16'h0007, busy low after CR.
REQ-033: Bytes "1G2",CR then "BEEF",CR -> parse_error on "G", no pulse on first CR, then value = 16'hBEEF.
REQ-034: TIMEOUT_CYCLES=16; "AB" then 16 idle cycles -> parse_error pulse, busy low; then "C",CR -> value = 16'h000C.
REQ-035: "12" then rst_n low 2 cycles, then "3",CR -> all outputs zero during reset, final value = 16'h0003.
